// File: rtl/instr_decode_stage.sv
// instr_decode_stage: decodes format A/B instruction words into operand fields,
// flags read-after-write hazards against the previous accepted instruction, and buffers results in a 2-entry skid FIFO.
`default_nettype none

module instr_decode_stage #(
    parameter int OP_WIDTH       = 5,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int PMS_WIDTH      = 5,
    parameter int SHIFT_WIDTH    = 5,
    parameter int RES_ADDR_WIDTH = 8,
    parameter int INSTR_WIDTH    = 32,
    parameter logic [2**OP_WIDTH-1:0] FMT_B_OPS   = '0,
    parameter logic [2**OP_WIDTH-1:0] ILLEGAL_OPS = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_WIDTH-1:0]    instr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OP_WIDTH-1:0]       operation,
    output logic [REG_ADDR_WIDTH-1:0] src_a,
    output logic [REG_ADDR_WIDTH-1:0] src_b,
    output logic [REG_ADDR_WIDTH-1:0] src_c,
    output logic [REG_ADDR_WIDTH-1:0] dest,
    output logic                      src_a_reg,
    output logic                      src_b_reg,
    output logic                      src_c_reg,
    output logic                      dest_reg,
    output logic                      saturate,
    output logic [SHIFT_WIDTH-1:0]    instr_shift,
    output logic [RES_ADDR_WIDTH-1:0] res_addr,
    output logic                      fmt_b,
    output logic                      illegal,
    output logic                      raw_hazard
);

    localparam int O  = OP_WIDTH;
    localparam int R  = REG_ADDR_WIDTH;
    localparam int TA = O + 4 * R;
    localparam int TB = O + 3 * R;

    typedef struct packed {
        logic [OP_WIDTH-1:0]       operation;
        logic [REG_ADDR_WIDTH-1:0] src_a;
        logic [REG_ADDR_WIDTH-1:0] src_b;
        logic [REG_ADDR_WIDTH-1:0] src_c;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic                      src_a_reg;
        logic                      src_b_reg;
        logic                      src_c_reg;
        logic                      dest_reg;
        logic                      saturate;
        logic [SHIFT_WIDTH-1:0]    instr_shift;
        logic [RES_ADDR_WIDTH-1:0] res_addr;
        logic                      fmt_b;
        logic                      illegal;
        logic                      raw_hazard;
    } entry_t;

    entry_t                      dec;
    entry_t                      head;
    entry_t                      mem_q [2];
    logic [1:0]                  count_q, count_d;
    logic                        rd_ptr_q, rd_ptr_d;
    logic                        wr_ptr_q, wr_ptr_d;
    logic                        in_ready_q, in_ready_d;
    logic                        last_valid_q, last_valid_d;
    logic                        last_dest_reg_q, last_dest_reg_d;
    logic [REG_ADDR_WIDTH-1:0]   last_dest_q, last_dest_d;
    logic                        push;
    logic                        pop;

    always_comb begin
        dec           = '0;
        dec.operation = instr[O-1:0];
        if (ILLEGAL_OPS[instr[O-1:0]]) begin
            dec.illegal = 1'b1;
        end else if (FMT_B_OPS[instr[O-1:0]]) begin
            dec.src_a     = instr[O +: R];
            dec.src_b     = instr[O+R +: R];
            dec.dest      = instr[O+2*R +: R];
            dec.src_a_reg = instr[TB];
            dec.src_b_reg = instr[TB+1];
            dec.dest_reg  = instr[TB+2];
            dec.res_addr  = instr[INSTR_WIDTH-1 -: RES_ADDR_WIDTH];
            dec.fmt_b     = 1'b1;
        end else begin
            dec.src_a       = instr[O +: R];
            dec.src_b       = instr[O+R +: R];
            dec.src_c       = instr[O+2*R +: R];
            dec.dest        = instr[O+3*R +: R];
            dec.src_a_reg   = instr[TA];
            dec.src_b_reg   = instr[TA+1];
            dec.src_c_reg   = instr[TA+2];
            dec.dest_reg    = instr[TA+3];
            dec.saturate    = ~instr[TA+4];
            dec.instr_shift = SHIFT_WIDTH'(instr[TA+5 +: PMS_WIDTH]);
        end
        // Operand flags are already zero for illegal entries, so no hazard can be raised for them.
        dec.raw_hazard = last_valid_q & last_dest_reg_q &
                         ((dec.src_a_reg & (dec.src_a == last_dest_q)) |
                          (dec.src_b_reg & (dec.src_b == last_dest_q)) |
                          (dec.src_c_reg & (dec.src_c == last_dest_q)));
    end

    assign out_valid = (count_q != 2'd0);
    assign in_ready  = in_ready_q;
    assign push      = in_valid & in_ready_q & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        count_d         = count_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d        = rd_ptr_q ^ pop;
        wr_ptr_d        = wr_ptr_q ^ push;
        last_valid_d    = last_valid_q;
        last_dest_d     = last_dest_q;
        last_dest_reg_d = last_dest_reg_q;
        if (flush) begin
            count_d      = 2'd0;
            rd_ptr_d     = 1'b0;
            wr_ptr_d     = 1'b0;
            last_valid_d = 1'b0;
        end else if (push) begin
            last_valid_d    = ~dec.illegal;
            last_dest_d     = dec.dest;
            last_dest_reg_d = dec.dest_reg;
        end
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q         <= 2'd0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            in_ready_q      <= 1'b1;
            last_valid_q    <= 1'b0;
            last_dest_q     <= '0;
            last_dest_reg_q <= 1'b0;
            mem_q[0]        <= '0;
            mem_q[1]        <= '0;
        end else begin
            count_q         <= count_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            in_ready_q      <= in_ready_d;
            last_valid_q    <= last_valid_d;
            last_dest_q     <= last_dest_d;
            last_dest_reg_q <= last_dest_reg_d;
            if (push) begin
                mem_q[wr_ptr_q] <= dec;
            end
        end
    end

    // Fields read as zero whenever nothing is buffered.
    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign operation   = head.operation;
    assign src_a       = head.src_a;
    assign src_b       = head.src_b;
    assign src_c       = head.src_c;
    assign dest        = head.dest;
    assign src_a_reg   = head.src_a_reg;
    assign src_b_reg   = head.src_b_reg;
    assign src_c_reg   = head.src_c_reg;
    assign dest_reg    = head.dest_reg;
    assign saturate    = head.saturate;
    assign instr_shift = head.instr_shift;
    assign res_addr    = head.res_addr;
    assign fmt_b       = head.fmt_b;
    assign illegal     = head.illegal;
    assign raw_hazard  = head.raw_hazard;

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed stimulus with a scoreboard queue checked by an independent output monitor.
`default_nettype none

module tb_instr_decode_stage;

    typedef struct packed {
        logic [4:0] op;
        logic [3:0] a, b, c, d;
        logic       ar, br, cr, dr, sat;
        logic [4:0] sh;
        logic [7:0] res;
        logic       fb, ill, raw;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] instr = '0;
    wire         in_ready, out_valid;
    wire  [4:0]  operation, instr_shift;
    wire  [3:0]  src_a, src_b, src_c, dest;
    wire         src_a_reg, src_b_reg, src_c_reg, dest_reg, saturate, fmt_b, illegal, raw_hazard;
    wire  [7:0]  res_addr;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t act, snap;

    instr_decode_stage #(
        .FMT_B_OPS  (32'h0000_0200),
        .ILLEGAL_OPS(32'h8000_0000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .operation(operation), .src_a(src_a), .src_b(src_b), .src_c(src_c), .dest(dest),
        .src_a_reg(src_a_reg), .src_b_reg(src_b_reg), .src_c_reg(src_c_reg), .dest_reg(dest_reg),
        .saturate(saturate), .instr_shift(instr_shift), .res_addr(res_addr),
        .fmt_b(fmt_b), .illegal(illegal), .raw_hazard(raw_hazard)
    );

    always #5 clk = ~clk;

    assign act = '{op: operation, a: src_a, b: src_b, c: src_c, d: dest,
                   ar: src_a_reg, br: src_b_reg, cr: src_c_reg, dr: dest_reg, sat: saturate,
                   sh: instr_shift, res: res_addr, fb: fmt_b, ill: illegal, raw: raw_hazard};

    function automatic logic [31:0] ia(input logic [4:0] op, input logic [3:0] a, b, c, d,
                                       input logic [3:0] ty, input logic nosat, input logic [4:0] pms);
        return {1'b1, pms, nosat, ty, d, c, b, a, op};
    endfunction

    function automatic logic [31:0] ib(input logic [4:0] op, input logic [3:0] a, b, d,
                                       input logic [2:0] fl, input logic [7:0] res);
        return {res, 4'hF, fl, d, b, a, op};
    endfunction

    function automatic exp_t ea(input logic [4:0] op, input logic [3:0] a, b, c, d, input logic [3:0] ty,
                                input logic sat, input logic [4:0] sh, input logic raw);
        exp_t e;
        e = '{op: op, a: a, b: b, c: c, d: d, ar: ty[0], br: ty[1], cr: ty[2], dr: ty[3],
              sat: sat, sh: sh, res: 8'h00, fb: 1'b0, ill: 1'b0, raw: raw};
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic issue(input logic [31:0] w, input exp_t e);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        in_valid = 1'b1;
        instr    = w;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
            n++;
            if (!done && n > 20) begin
                checks++;
                failures++;
                $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", n);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out: got %h expected no output", act);
                end else begin
                    e = sb.pop_front();
                    if (act !== e) begin
                        failures++;
                        $display("FAIL out_entry: got %h expected %h", act, e);
                    end
                end
            end
        end
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_fields", 64'(act), 64'd0);
        reset_n = 1'b1;
        idle(1);

        // Format A with default fields, then latency-one presentation
        issue(ia(5'd3, 4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b0, 5'd7),
              ea(5'd3, 4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b1, 5'd7, 1'b0));
        chk("latency1_out_valid", 64'(out_valid), 64'd1);
        // Format B
        issue(ib(5'd9, 4'd5, 4'd6, 4'd7, 3'b101, 8'hA5),
              '{op: 5'd9, a: 4'd5, b: 4'd6, c: 4'd0, d: 4'd7, ar: 1'b1, br: 1'b0, cr: 1'b0, dr: 1'b1,
                sat: 1'b0, sh: 5'd0, res: 8'hA5, fb: 1'b1, ill: 1'b0, raw: 1'b0});
        // Hazard chain
        issue(ia(5'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b0, 5'd0),
              ea(5'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b1, 5'd0, 1'b0));
        issue(ia(5'd2, 4'd0, 4'd4, 4'd5, 4'd6, 4'b1111, 1'b1, 5'd0),
              ea(5'd2, 4'd0, 4'd4, 4'd5, 4'd6, 4'b1111, 1'b0, 5'd0, 1'b1));
        issue(ia(5'd2, 4'd1, 4'd2, 4'd3, 4'd8, 4'b1111, 1'b0, 5'd1),
              ea(5'd2, 4'd1, 4'd2, 4'd3, 4'd8, 4'b1111, 1'b1, 5'd1, 1'b0));
        issue(ia(5'd2, 4'd8, 4'd1, 4'd2, 4'd9, 4'b1110, 1'b0, 5'd2),
              ea(5'd2, 4'd8, 4'd1, 4'd2, 4'd9, 4'b1110, 1'b1, 5'd2, 1'b0));
        // Illegal opcode clears fields and the tracker
        issue(ia(5'd31, 4'd9, 4'd9, 4'd9, 4'd9, 4'b1111, 1'b0, 5'd3),
              '{op: 5'd31, a: 4'd0, b: 4'd0, c: 4'd0, d: 4'd0, ar: 1'b0, br: 1'b0, cr: 1'b0, dr: 1'b0,
                sat: 1'b0, sh: 5'd0, res: 8'h00, fb: 1'b0, ill: 1'b1, raw: 1'b0});
        issue(ia(5'd2, 4'd9, 4'd9, 4'd9, 4'd1, 4'b1111, 1'b0, 5'd4),
              ea(5'd2, 4'd9, 4'd9, 4'd9, 4'd1, 4'b1111, 1'b1, 5'd4, 1'b0));
        issue(ia(5'd2, 4'd1, 4'd2, 4'd3, 4'd5, 4'b0111, 1'b0, 5'd31),
              ea(5'd2, 4'd1, 4'd2, 4'd3, 4'd5, 4'b0111, 1'b1, 5'd31, 1'b1));
        issue(ia(5'd2, 4'd5, 4'd2, 4'd3, 4'd6, 4'b1111, 1'b0, 5'd5),
              ea(5'd2, 4'd5, 4'd2, 4'd3, 4'd6, 4'b1111, 1'b1, 5'd5, 1'b0));
        idle(3);
        chk("drained_out_valid", 64'(out_valid), 64'd0);
        chk("drained_in_ready", 64'(in_ready), 64'd1);

        // Backpressure: two fill the buffer, third is held until drain
        out_ready = 1'b0;
        issue(ia(5'd4, 4'd1, 4'd2, 4'd3, 4'd10, 4'b1111, 1'b0, 5'd6),
              ea(5'd4, 4'd1, 4'd2, 4'd3, 4'd10, 4'b1111, 1'b1, 5'd6, 1'b0));
        issue(ia(5'd5, 4'd0, 4'd1, 4'd2, 4'd11, 4'b1111, 1'b0, 5'd7),
              ea(5'd5, 4'd0, 4'd1, 4'd2, 4'd11, 4'b1111, 1'b1, 5'd7, 1'b0));
        in_valid = 1'b1;
        instr    = ia(5'd6, 4'd11, 4'd0, 4'd0, 4'd12, 4'b1111, 1'b0, 5'd8);
        @(negedge clk);
        snap = act;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_stable", 64'(act), 64'(snap));
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(ia(5'd6, 4'd11, 4'd0, 4'd0, 4'd12, 4'b1111, 1'b0, 5'd8),
              ea(5'd6, 4'd11, 4'd0, 4'd0, 4'd12, 4'b1111, 1'b1, 5'd8, 1'b1));
        idle(4);
        chk("bp_drain_queue", 64'(sb.size()), 64'd0);

        // Flush with two entries buffered; input during flush is dropped
        out_ready = 1'b0;
        issue(ia(5'd7, 4'd1, 4'd2, 4'd3, 4'd13, 4'b1111, 1'b0, 5'd0),
              ea(5'd7, 4'd1, 4'd2, 4'd3, 4'd13, 4'b1111, 1'b1, 5'd0, 1'b0));
        issue(ia(5'd7, 4'd1, 4'd2, 4'd3, 4'd14, 4'b1111, 1'b0, 5'd0),
              ea(5'd7, 4'd1, 4'd2, 4'd3, 4'd14, 4'b1111, 1'b1, 5'd0, 1'b0));
        flush    = 1'b1;
        in_valid = 1'b1;
        instr    = ia(5'd8, 4'd1, 4'd1, 4'd1, 4'd1, 4'b1111, 1'b0, 5'd0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        idle(2);
        chk("flush_no_output", 64'(out_valid), 64'd0);
        issue(ia(5'd8, 4'd14, 4'd2, 4'd3, 4'd15, 4'b1111, 1'b0, 5'd0),
              ea(5'd8, 4'd14, 4'd2, 4'd3, 4'd15, 4'b1111, 1'b1, 5'd0, 1'b0));
        idle(3);

        // Reset mid-stream with two entries buffered
        out_ready = 1'b0;
        issue(ia(5'd10, 4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b0, 5'd9),
              ea(5'd10, 4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b1, 5'd9, 1'b0));
        issue(ia(5'd11, 4'd1, 4'd2, 4'd3, 4'd5, 4'b1111, 1'b0, 5'd9),
              ea(5'd11, 4'd1, 4'd2, 4'd3, 4'd5, 4'b1111, 1'b1, 5'd9, 1'b0));
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        sb.delete();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fields", 64'(act), 64'd0);
        out_ready = 1'b1;
        idle(3);
        chk("rst_no_partial", 64'(out_valid), 64'd0);
        chk("rst_empty_pop_in_ready", 64'(in_ready), 64'd1);
        issue(ia(5'd12, 4'd5, 4'd5, 4'd5, 4'd6, 4'b1111, 1'b0, 5'd10),
              ea(5'd12, 4'd5, 4'd5, 4'd5, 4'd6, 4'b1111, 1'b1, 5'd10, 1'b0));
        idle(3);
        chk("final_queue_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- OP_WIDTH, 5, opcode field width.
- REG_ADDR_WIDTH, 4, register/operand address width.
- PMS_WIDTH, 5, post-multiply shift field width.
- SHIFT_WIDTH, 5, output shift width; must be >= PMS_WIDTH.
- RES_ADDR_WIDTH, 8, resource address width.
- INSTR_WIDTH, 32, instruction word width.
- FMT_B_OPS, 2**OP_WIDTH-bit mask; bit n set means opcode n is format B.
- ILLEGAL_OPS, 2**OP_WIDTH-bit mask; bit n set means opcode n is illegal.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock; all state changes on its rising edge.
- reset_n, in, 1, synchronous active-low reset.
- flush, in, 1, synchronous buffer and hazard-tracker clear.
- in_valid, in, 1, instruction present.
- in_ready, out, 1, stage can accept.
- instr, in, INSTR_WIDTH, instruction word.
- out_valid, out, 1, decoded entry present.
- out_ready, in, 1, consumer accepts.
- operation, out, OP_WIDTH, opcode.
- src_a, src_b, src_c, dest, out, REG_ADDR_WIDTH each, operand addresses.
- src_a_reg, src_b_reg, src_c_reg, dest_reg, out, 1 each, operand-is-register flags.
- saturate, out, 1, saturate result.
- instr_shift, out, SHIFT_WIDTH, zero-extended PMS.
- res_addr, out, RES_ADDR_WIDTH, resource address.
- fmt_b, out, 1, entry is format B.
- illegal, out, 1, opcode flagged in ILLEGAL_OPS.
- raw_hazard, out, 1, entry reads the previous accepted instruction's register dest.

Function
REQ-003 Field positions: let O = OP_WIDTH and R = REG_ADDR_WIDTH; operation = instr[O-1:0]; src_a = instr[O+R-1:O]; src_b = next R bits.

REQ-004 Format A (FMT_B_OPS[op]=0) SHALL decode as follows:
- src_c = instr[O+3R-1:O+2R]; dest = instr[O+4R-1:O+3R].
- Type flags a, b, c, dest at bits T = O+4R through T+3.
- saturate = ~instr[T+4].
- instr_shift = zero-extended instr[T+5+PMS_WIDTH-1:T+5].
- res_addr = 0; fmt_b = 0.

REQ-005 Format B SHALL decode as follows:
- dest = instr[O+3R-1:O+2R].
- Type flags a, b, dest at bits O+3R through O+3R+2.
- src_c = 0; src_c_reg = 0; saturate = 0; instr_shift = 0.
- res_addr = instr[INSTR_WIDTH-1:INSTR_WIDTH-RES_ADDR_WIDTH]; fmt_b = 1.

REQ-006 When ILLEGAL_OPS[op] is set, illegal SHALL be 1, operation SHALL pass through, and all other decoded fields and raw_hazard SHALL be 0.

REQ-007 A transfer SHALL occur on a cycle where valid and ready are both 1; an input transfer SHALL be accepted and decoded into a 2-entry FIFO (skid buffer).

REQ-008 The outputs SHALL present the FIFO head; the decoded output SHALL appear the cycle after acceptance (latency 1), and back-to-back throughput SHALL be 1 per cycle while out_ready=1.

REQ-009 in_ready SHALL be registered and equal 1 iff FIFO occupancy is below 2 at the start of the cycle; it SHALL not combinationally depend on out_ready.

REQ-010 A simultaneous input and output transfer SHALL leave occupancy unchanged, including at occupancy 2 when in_ready=0 (no input transfer then occurs).

REQ-011 Output fields SHALL remain stable while out_valid=1 and out_ready=0.

REQ-012 The hazard tracker SHALL behave as follows:
- It holds last_dest, last_dest_reg and last_valid, updated on every accepted legal instruction.
- An accepted illegal instruction SHALL clear last_valid.
- raw_hazard = last_valid & last_dest_reg & OR over operands x of (x_reg & x==last_dest), evaluated at acceptance against the previous accepted instruction.

REQ-013 flush SHALL empty the FIFO (out_valid=0 next cycle), clear last_valid and set in_ready=1 next cycle.
- An input presented during flush SHALL be discarded.
- flush SHALL take priority over all transfers.

REQ-014 Occupancy SHALL never exceed 2 or underflow below 0; an out_ready pulse while empty SHALL have no effect.

Reset
REQ-015 While reset_n=0 at a clock edge, the next state SHALL be:
- Occupancy 0, out_valid=0, in_ready=1, last_valid=0.
- All decoded output fields 0.
- reset_n SHALL take priority over flush and transfers.

REQ-016 Reset asserted mid-stream SHALL discard all buffered entries with no partial outputs afterwards.

Verification
REQ-017 Format A, defaults:
- Stimulus: op=3, src_a=1, src_b=2, src_c=3, dest=4, types=4'b1111, no-sat bit=0, pms=7, out_ready=1.
- Response: the next cycle shows out_valid=1 with those fields, saturate=1, instr_shift=7, res_addr=0, fmt_b=0.

REQ-018 Format B:
- Stimulus: FMT_B_OPS bit 9 set; op=9, src_a=5, src_b=6, dest=7, flags=3'b101, instr[31:24]=8'hA5.
- Response: fmt_b=1, res_addr=8'hA5, src_c=0, saturate=0, instr_shift=0, src_a_reg=1, src_b_reg=0, dest_reg=1.

REQ-019 Backpressure:
- Stimulus: out_ready=0 with 3 consecutive valid inputs.
- Response: in_ready falls after 2 acceptances; the third input is held; out_ready=1 then drains entries in order with no loss or duplication.

REQ-020 Hazard:
- Stimulus: instruction writing reg 4 (dest_reg=1), followed by one reading src_b=4 (src_b_reg=1).
- Response: raw_hazard=1 on the second; a third instruction with no matching source gives raw_hazard=0.

REQ-021 Illegal and flush:
- Stimulus: an ILLEGAL_OPS opcode.
- Response: illegal=1, fields 0, and the following instruction has raw_hazard=0.
- Stimulus: flush with 2 entries buffered.
- Response: out_valid=0 and in_ready=1 next cycle.

REQ-022 Reset mid-stream:
- Stimulus: reset_n=0 for 1 cycle with 2 entries buffered.
- Response: out_valid=0, all fields 0, in_ready=1.
